// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and RAM bus strobes of the load/store unit
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_address;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic                  bus_write_address;
    logic                  bus_read;
    logic                  bus_write;
    logic [1:0]            bus_data_size;

    // master: the load/store unit, initiator of the RAM bus
    modport master (
        input  req_valid, req_write, req_funct3, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output bus_address, bus_write_address, bus_read, bus_write, bus_data_size
    );

    // slave: execute stage plus RAM responder
    modport slave (
        output req_valid, req_write, req_funct3, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  bus_address, bus_write_address, bus_read, bus_write, bus_data_size
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store requests to byte-addressed RAM bus initiator
module load_store_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.master  lsu,
    inout  wire  [31:0]        bus_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  error_q, error_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  accept;
    logic                  bus_active;
    logic                  drive_data;
    logic                  unused_addr_bits;

    function automatic logic funct3_ok(input logic is_write, input logic [2:0] f3);
        if (is_write) begin
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [1:0] size_code(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    assign unused_addr_bits = ^lsu.req_address[31:ADDR_WIDTH];

    // Reset gates the handshake so a request held during reset is never taken.
    assign lsu.req_ready = (state_q == IDLE) && !reset;
    assign accept        = lsu.req_valid && lsu.req_ready;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        error_d  = error_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = lsu.req_write;
                    funct3_d = lsu.req_funct3;
                    addr_d   = lsu.req_address[ADDR_WIDTH-1:0];
                    wdata_d  = lsu.req_wdata;
                    error_d  = !funct3_ok(lsu.req_write, lsu.req_funct3);
                    rdata_d  = 32'd0;
                    state_d  = funct3_ok(lsu.req_write, lsu.req_funct3) ? ADDR : RESP;
                end
            end
            ADDR: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                rdata_d = write_q ? 32'd0 : extend_load(funct3_q, bus_data);
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            error_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            error_q  <= error_d;
            rdata_q  <= rdata_d;
        end
    end

    // Error transactions never touch the bus, so they present no address or size.
    assign bus_active            = (state_q != IDLE) && !error_q;
    assign lsu.bus_address       = bus_active ? addr_q : '0;
    assign lsu.bus_data_size     = bus_active ? size_code(funct3_q[1:0]) : 2'b00;

    assign lsu.bus_write_address = (state_q == ADDR) && !reset;
    assign lsu.bus_read          = (state_q == ACCESS) && !write_q && !reset;
    assign lsu.bus_write         = (state_q == ACCESS) && write_q && !reset;

    assign drive_data = (state_q == ACCESS) && write_q && !reset;
    assign bus_data   = drive_data ? wdata_q : 32'bz;

    assign lsu.resp_valid = (state_q == RESP) && !reset;
    assign lsu.resp_rdata = lsu.resp_valid ? rdata_q : 32'd0;
    assign lsu.resp_error = lsu.resp_valid && error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table plus scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    load_store_unit_if #(.ADDR_WIDTH(16)) lsu ();
    wire [31:0] bus_data;

    load_store_unit #(.ADDR_WIDTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .lsu      (lsu.master),
        .bus_data (bus_data)
    );

    // RAM responder: drives read data during bus_read, a zero probe whenever the DUT must be high-Z
    logic [7:0]  mem [0:65535];
    logic [15:0] ram_addr = 16'd0;
    logic        tb_en;
    logic [31:0] tb_val;

    always_comb begin
        tb_en  = !lsu.bus_write;
        tb_val = lsu.bus_read ? {mem[ram_addr + 16'd3], mem[ram_addr + 16'd2],
                                 mem[ram_addr + 16'd1], mem[ram_addr]} : 32'd0;
    end
    assign bus_data = tb_en ? tb_val : 32'bz;

    always @(posedge clock) begin
        if (lsu.bus_write) begin
            mem[ram_addr] = bus_data[7:0];
            if (lsu.bus_data_size != 2'b00) mem[ram_addr + 16'd1] = bus_data[15:8];
            if (lsu.bus_data_size == 2'b11) begin
                mem[ram_addr + 16'd2] = bus_data[23:16];
                mem[ram_addr + 16'd3] = bus_data[31:24];
            end
        end
        if (lsu.bus_write_address) ram_addr = lsu.bus_address;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t sbq[$];

    int          wa_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] wa_addr = 16'd0;
    logic [1:0]  acc_size = 2'b00;

    always @(negedge clock) begin
        if (!reset) begin
            if (lsu.bus_write_address) begin
                wa_cnt++;
                wa_addr = lsu.bus_address;
            end
            if (lsu.bus_read) begin
                rd_cnt++;
                acc_size = lsu.bus_data_size;
            end
            if (lsu.bus_write) begin
                wr_cnt++;
                acc_size = lsu.bus_data_size;
            end
            if (lsu.bus_read && lsu.bus_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
            if (!lsu.bus_write) chk("bus_data_hiz", bus_data, tb_val);
            if (lsu.resp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = sbq.pop_front();
                    chk("resp_rdata", lsu.resp_rdata, e.rdata);
                    chk("resp_error", {31'd0, lsu.resp_error}, {31'd0, e.err});
                end
            end else if (lsu.resp_rdata != 32'd0 || lsu.resp_error) begin
                chk("resp_idle_zero", {lsu.resp_rdata[30:0], lsu.resp_error}, 32'd0);
            end
        end
    end

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_size;
    } vec_t;

    task automatic issue(input vec_t v, input bit expect_resp, output int waits);
        logic ready_s;
        lsu.req_valid   = 1'b1;
        lsu.req_write   = v.write;
        lsu.req_funct3  = v.f3;
        lsu.req_address = v.addr;
        lsu.req_wdata   = v.wdata;
        if (expect_resp) sbq.push_back('{v.exp_rdata, v.exp_err});
        waits = 0;
        forever begin
            ready_s = lsu.req_ready;
            @(posedge clock);
            #1;
            if (ready_s) break;
            waits++;
            if (waits > 10) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        lsu.req_valid   = 1'b0;
        lsu.req_write   = 1'($urandom);
        lsu.req_funct3  = 3'($urandom);
        lsu.req_address = $urandom;
        lsu.req_wdata   = $urandom;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!lsu.resp_valid && lat < 12);
        #1;
    endtask

    vec_t vecs[19];

    initial begin
        int waits;
        int lat;
        int wa0, rd0, wr0;
        vec_t v;

        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hFFFF_FF80, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 3'd4, 32'h0000_0010, 32'h0,         32'h0000_0080, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 3'd1, 32'h0000_0011, 32'h0,         32'h0000_347F, 1'b0, 2'b01};
        vecs[3]  = '{1'b0, 3'd5, 32'h0000_0010, 32'h0,         32'h0000_7F80, 1'b0, 2'b01};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'h1234_7F80, 1'b0, 2'b11};
        vecs[5]  = '{1'b0, 3'd1, 32'h0000_0013, 32'h0,         32'hFFFF_8512, 1'b0, 2'b01};
        vecs[6]  = '{1'b0, 3'd5, 32'h0000_0013, 32'h0,         32'h0000_8512, 1'b0, 2'b01};
        vecs[7]  = '{1'b0, 3'd0, 32'h0000_0011, 32'h0,         32'h0000_007F, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 3'd2, 32'hABCD_0010, 32'h0,         32'h1234_7F80, 1'b0, 2'b11};
        vecs[9]  = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 2'b00};
        vecs[10] = '{1'b1, 3'd0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         1'b0, 2'b00};
        vecs[11] = '{1'b1, 3'd4, 32'h0000_0024, 32'h5555_5555, 32'h0,         1'b1, 2'b00};
        vecs[12] = '{1'b1, 3'd2, 32'h0000_0031, 32'hCAFE_F00D, 32'h0,         1'b0, 2'b11};
        vecs[13] = '{1'b0, 3'd2, 32'h0000_0031, 32'h0,         32'hCAFE_F00D, 1'b0, 2'b11};
        vecs[14] = '{1'b0, 3'd7, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 2'b00};
        vecs[15] = '{1'b1, 3'd1, 32'h0000_0050, 32'h1234_BEEF, 32'h0,         1'b0, 2'b01};
        vecs[16] = '{1'b0, 3'd1, 32'h0000_0050, 32'h0,         32'hFFFF_BEEF, 1'b0, 2'b01};
        vecs[17] = '{1'b0, 3'd2, 32'h0000_0050, 32'h0,         32'h0000_BEEF, 1'b0, 2'b11};
        vecs[18] = '{1'b0, 3'd6, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 2'b00};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'h80; mem[16'h11] = 8'h7F; mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
        mem[16'h14] = 8'h85;
        mem[16'h21] = 8'hAA; mem[16'h22] = 8'hAA; mem[16'h23] = 8'hAA;

        // a valid load held during reset must not be taken
        lsu.req_valid   = 1'b1;
        lsu.req_write   = 1'b0;
        lsu.req_funct3  = 3'd2;
        lsu.req_address = 32'h10;
        lsu.req_wdata   = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        lsu.req_valid = 1'b0;

        @(negedge clock);
        chk("rst_req_ready", {31'd0, lsu.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, lsu.resp_valid}, 32'd0);
        chk("rst_resp_rdata", lsu.resp_rdata, 32'd0);
        chk("rst_bus_address", {16'd0, lsu.bus_address}, 32'd0);
        chk("rst_bus_strobes", {29'd0, lsu.bus_write_address, lsu.bus_read, lsu.bus_write}, 32'd0);
        chk("rst_bus_size", {30'd0, lsu.bus_data_size}, 32'd0);
        repeat (5) @(negedge clock);
        chk("rst_no_access", wa_cnt, 32'd0);

        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            wa0 = wa_cnt;
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            issue(v, 1'b1, waits);
            chk($sformatf("v%0d_accept_wait", i), waits, (i == 0) ? 32'd0 : 32'd1);
            wait_resp(lat);
            chk($sformatf("v%0d_latency", i), lat, v.exp_err ? 32'd1 : 32'd3);
            chk($sformatf("v%0d_wa_pulses", i), wa_cnt - wa0, v.exp_err ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_rd_pulses", i), rd_cnt - rd0, (!v.exp_err && !v.write) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_wr_pulses", i), wr_cnt - wr0, (!v.exp_err && v.write) ? 32'd1 : 32'd0);
            if (!v.exp_err) begin
                chk($sformatf("v%0d_bus_addr", i), {16'd0, wa_addr}, {16'd0, v.addr[15:0]});
                chk($sformatf("v%0d_bus_size", i), {30'd0, acc_size}, {30'd0, v.exp_size});
            end
        end

        @(negedge clock);
        chk("sb_byte0", {24'd0, mem[16'h20]}, 32'hEF);
        chk("sb_byte1", {24'd0, mem[16'h21]}, 32'hAA);
        chk("sb_byte2", {24'd0, mem[16'h22]}, 32'hAA);
        chk("sb_byte3", {24'd0, mem[16'h23]}, 32'hAA);
        chk("sh_upper", {mem[16'h53], mem[16'h52], 16'd0}, 32'd0);

        // reset landing on a store's ACCESS cycle aborts it with no RAM write and no response
        repeat (2) @(negedge clock);
        wr0 = wr_cnt;
        v = '{1'b1, 3'd2, 32'h0000_0040, 32'h1122_3344, 32'h0, 1'b0, 2'b11};
        issue(v, 1'b0, waits);
        chk("abort_accept_wait", waits, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_req_ready", {31'd0, lsu.req_ready}, 32'd1);
        repeat (5) @(negedge clock);
        chk("abort_mem", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]}, 32'd0);
        chk("abort_wr_pulses", wr_cnt - wr0, 32'd0);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
